sub_bytes_pipe: RTL and testbench
=================================

SUB_BYTES_PIPE -- requirements
Module: sub_bytes_pipe

Interface
REQ-001 The block SHALL have parameter LANES, default 4, giving the number of bytes substituted per transfer; legal values are 1..16.
REQ-002 The block SHALL have parameter OUT_REG, default 1; 1 adds the output register stage and 0 drives the stage-2 outputs directly from the lookup.
REQ-003 i_Clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 i_Rst  input  1  reset, synchronous, active-high.
REQ-005 i_Valid  input  1  input word present.
REQ-006 o_Ready  output  1  block accepts the input word this cycle.
REQ-007 i_Inv  input  1  mode for this word: 0 selects forward S-box, 1 selects inverse S-box.
REQ-008 i_Data  input  8*LANES  input bytes; lane k occupies bits [8k+7:8k].
REQ-009 o_Valid  output  1  result word present.
REQ-010 i_Ready  input  1  downstream accepts the result this cycle.
REQ-011 o_Data  output  8*LANES  substituted bytes, in the same lane order as i_Data.
REQ-012 o_Inv  output  1  mode that travelled with the word.
REQ-013 o_Busy  output  1  at least one word is held in the pipeline.

Function
REQ-014 A transfer SHALL occur on a cycle where valid and ready are both 1; data SHALL be ignored otherwise.
REQ-015 Stage 1 SHALL register i_Data and i_Inv on an accepted transfer. Stage 2 (OUT_REG=1) SHALL register the per-lane lookup of the stage-1 bytes.
REQ-016 Each lane SHALL apply FIPS-197 SubBytes when the mode bit is 0 and InvSubBytes when it is 1. Lanes SHALL be independent.
REQ-017 Latency from acceptance to o_Valid SHALL be 2 cycles when OUT_REG=1 and 1 cycle when OUT_REG=0, provided there is no stall.
REQ-018 Each stage SHALL hold one valid flag. A stage SHALL load when it is empty or when its contents move downstream in the same cycle.
REQ-019 o_Ready SHALL be ~s1_valid | ~s2_valid | i_Ready. Full throughput of one word per cycle SHALL be sustained while i_Ready=1.
REQ-020 While o_Valid=1 and i_Ready=0, o_Data and o_Inv SHALL hold stable and stage 2 SHALL NOT change.
REQ-021 When both stages are full and i_Ready=0, o_Ready SHALL be 0 and no word SHALL be dropped or duplicated.
REQ-022 Mode MAY change on every word, and each word SHALL use its own i_Inv.
REQ-023 Simultaneous input acceptance and output consumption SHALL both take effect in the same cycle.
REQ-024 o_Busy SHALL equal s1_valid | s2_valid.

Reset
REQ-025 While i_Rst=1 at a clock edge, all valid flags SHALL clear, giving o_Valid=0 and o_Busy=0.
REQ-026 During reset, o_Ready SHALL read 1, but no transfer SHALL be recorded.
REQ-027 o_Data and o_Inv SHALL reset to 0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight words. The first word accepted after reset deasserts SHALL emerge with the nominal latency.

Structure
REQ-029 Shared package aes_pkg SHALL hold the 256-entry forward and inverse S-box constant tables and the byte-width constant.
REQ-030 A single combinational sub-module sbox_lut (ports: byte in, mode in, byte out) SHALL be instantiated LANES times.
REQ-031 All registers, valid flags and handshake logic SHALL reside in sub_bytes_pipe.

Verification
REQ-032 Setup LANES=4, OUT_REG=1, i_Ready=1. Accept i_Data=32'h53_00_01_FF with i_Inv=0. Two cycles later o_Valid=1 and o_Data=32'hED_63_7C_16.
REQ-033 Send the same word with i_Inv=1. Result o_Data=32'h50_52_09_7D and o_Inv=1.
REQ-034 Stream 256 back-to-back words with alternating mode, covering every byte value in every lane. Outputs SHALL match the reference tables in order, and o_Ready SHALL stay 1 throughout.
REQ-035 Fill the pipe with i_Ready=0 for 5 cycles. o_Ready SHALL drop after 2 accepted words, and o_Data SHALL remain stable. Then raise i_Ready: both words SHALL emerge in order with no loss or duplication.
REQ-036 Assert i_Rst for one cycle with 2 words in flight. Next cycle o_Valid=0 and o_Busy=0, and a fresh word SHALL appear 2 cycles after acceptance.
REQ-037 Setup LANES=1, OUT_REG=0. Accept input 8'h00 with i_Inv=0. Next cycle o_Data=8'h63.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES byte-substitution constants: the forward and inverse S-box
// tables from FIPS-197, indexed by the input byte value.
package aes_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic {
    SBOX_FWD = 1'b0,
    SBOX_INV = 1'b1
  } sbox_mode_e;

  localparam byte_t FWD_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/sbox_lut.sv
// One byte lane of the substitution: purely combinational table lookup,
// forward or inverse according to the mode bit travelling with the word.
module sbox_lut
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] i_byte,
  input  logic              i_inv,
  output logic [BYTE_W-1:0] o_byte
);

  always_comb begin
    o_byte = FWD_SBOX[i_byte];
    if (sbox_mode_e'(i_inv) == SBOX_INV) begin
      o_byte = INV_SBOX[i_byte];
    end
  end

endmodule

// File: rtl/sub_bytes_pipe.sv
// Two-stage valid/ready pipeline applying AES SubBytes / InvSubBytes to
// LANES independent bytes per word; OUT_REG=0 collapses it to one stage.
module sub_bytes_pipe
  import aes_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int OUT_REG = 1
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Valid,
  output logic                    o_Ready,
  input  logic                    i_Inv,
  input  logic [BYTE_W*LANES-1:0] i_Data,
  output logic                    o_Valid,
  input  logic                    i_Ready,
  output logic [BYTE_W*LANES-1:0] o_Data,
  output logic                    o_Inv,
  output logic                    o_Busy
);

  localparam int DW = BYTE_W * LANES;

  // Handshake: a word moves on any edge where valid and ready are both high;
  // valid never waits on ready, and data is don't-care while valid is low.

  logic          s1_valid_q, s1_valid_d;
  logic [DW-1:0] s1_data_q, s1_data_d;
  logic          s1_inv_q, s1_inv_d;
  logic [DW-1:0] lut_data;
  logic          s2_free;
  logic          accept;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sbox_lut u_sbox_lut (
      .i_byte (s1_data_q[k*BYTE_W +: BYTE_W]),
      .i_inv  (s1_inv_q),
      .o_byte (lut_data[k*BYTE_W +: BYTE_W])
    );
  end

  // Ready reads high throughout reset, but the reset branch below wins, so
  // nothing is actually captured.
  assign o_Ready = i_Rst | ~s1_valid_q | s2_free;
  assign accept  = i_Valid & (~s1_valid_q | s2_free);

  always_comb begin
    s1_valid_d = accept | (s1_valid_q & ~s2_free);
    s1_data_d  = s1_data_q;
    s1_inv_d   = s1_inv_q;
    if (accept) begin
      s1_data_d = i_Data;
      s1_inv_d  = i_Inv;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_inv_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_inv_q   <= s1_inv_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic          s2_valid_q, s2_valid_d;
    logic [DW-1:0] s2_data_q, s2_data_d;
    logic          s2_inv_q, s2_inv_d;

    assign s2_free = ~s2_valid_q | i_Ready;

    always_comb begin
      s2_valid_d = s2_valid_q & ~i_Ready;
      s2_data_d  = s2_data_q;
      s2_inv_d   = s2_inv_q;
      if (s1_valid_q & s2_free) begin
        s2_valid_d = 1'b1;
        s2_data_d  = lut_data;
        s2_inv_d   = s1_inv_q;
      end
    end

    always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
        s2_inv_q   <= 1'b0;
      end else begin
        s2_valid_q <= s2_valid_d;
        s2_data_q  <= s2_data_d;
        s2_inv_q   <= s2_inv_d;
      end
    end

    assign o_Valid = s2_valid_q;
    assign o_Data  = s2_data_q;
    assign o_Inv   = s2_inv_q;
    assign o_Busy  = s1_valid_q | s2_valid_q;
  end else begin : g_no_out_reg
    // Outputs come straight off the lookup; masking keeps them at zero
    // whenever nothing is held, including straight out of reset.
    assign s2_free = i_Ready;
    assign o_Valid = s1_valid_q;
    assign o_Data  = s1_valid_q ? lut_data : '0;
    assign o_Inv   = s1_valid_q & s1_inv_q;
    assign o_Busy  = s1_valid_q;
  end

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Bench for sub_bytes_pipe: a 4-lane registered instance and a 1-lane
// unregistered instance, checked against an S-box built from GF(2^8) maths.
module tb_sub_bytes_pipe;

  logic clk;
  logic rst;

  logic        a_valid, a_ready, a_inv, a_ovalid, a_iready, a_oinv, a_busy;
  logic [31:0] a_data, a_odata;
  logic        b_valid, b_ready, b_inv, b_ovalid, b_iready, b_oinv, b_busy;
  logic [7:0]  b_data, b_odata;

  logic [32:0] exp_q_a[$];
  logic [8:0]  exp_q_b[$];
  logic [32:0] exp_a;
  logic [8:0]  exp_b;

  logic [7:0] fwd_ref [256];
  logic [7:0] inv_ref [256];

  int n_checks;
  int n_pass;

  sub_bytes_pipe #(.LANES(4), .OUT_REG(1)) u_dut_a (
    .i_Clk (clk), .i_Rst (rst), .i_Valid (a_valid), .o_Ready (a_ready),
    .i_Inv (a_inv), .i_Data (a_data), .o_Valid (a_ovalid), .i_Ready (a_iready),
    .o_Data (a_odata), .o_Inv (a_oinv), .o_Busy (a_busy)
  );

  sub_bytes_pipe #(.LANES(1), .OUT_REG(0)) u_dut_b (
    .i_Clk (clk), .i_Rst (rst), .i_Valid (b_valid), .o_Ready (b_ready),
    .i_Inv (b_inv), .i_Data (b_data), .o_Valid (b_ovalid), .i_Ready (b_iready),
    .o_Data (b_odata), .o_Inv (b_oinv), .o_Busy (b_busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before 2ms");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_ref();
    logic [7:0] inv_x, s;
    for (int x = 0; x < 256; x++) begin
      inv_x = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv_x = 8'(y);
      end
      s = inv_x ^ rotl8(inv_x, 1) ^ rotl8(inv_x, 2) ^ rotl8(inv_x, 3) ^ rotl8(inv_x, 4) ^ 8'h63;
      fwd_ref[x] = s;
      inv_ref[s] = 8'(x);
    end
  endtask

  function automatic logic [7:0] sub_ref(input logic [7:0] v, input logic inv);
    return inv ? inv_ref[v] : fwd_ref[v];
  endfunction

  function automatic logic [32:0] model_a(input logic [31:0] d, input logic inv);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = sub_ref(d[8*k +: 8], inv);
    return {inv, r};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h required %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got event 1 required 0", name);
  endtask

  always @(negedge clk) begin
    if (!rst && a_ovalid && a_iready) begin
      if (exp_q_a.size() == 0) fail_now("a_unexpected_output");
      else begin
        exp_a = exp_q_a.pop_front();
        check("a_out", 64'({a_oinv, a_odata}), 64'(exp_a));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_ovalid && b_iready) begin
      if (exp_q_b.size() == 0) fail_now("b_unexpected_output");
      else begin
        exp_b = exp_q_b.pop_front();
        check("b_out", 64'({b_oinv, b_odata}), 64'(exp_b));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_a(input logic [31:0] d, input logic inv);
    bit done;
    done = 0;
    a_valid = 1'b1; a_data = d; a_inv = inv;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (a_ready) begin
        exp_q_a.push_back(model_a(d, inv));
        done = 1;
      end
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    if (!done) fail_now("send_a_timeout");
  endtask

  // Pipe must be empty and a_iready high on entry.
  task automatic lat_check_a(input string name, input logic [31:0] d, input logic inv,
                             input logic [32:0] exp);
    a_valid = 1'b1; a_data = d; a_inv = inv;
    @(negedge clk);
    check({name, "_accept"}, 64'(a_ready), 64'd1);
    exp_q_a.push_back(exp);
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    check({name, "_early"}, 64'(a_ovalid), 64'd0);
    @(negedge clk);
    check({name, "_valid"}, 64'(a_ovalid), 64'd1);
    check({name, "_data"}, 64'({a_oinv, a_odata}), 64'(exp));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 100 && (exp_q_a.size() != 0 || exp_q_b.size() != 0); c++) @(posedge clk);
    #1;
    check(name, 64'(exp_q_a.size() + exp_q_b.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic [32:0] hold;
    bit          have_hold, acc;
    int          n_acc, ready_drops;

    n_checks = 0; n_pass = 0;
    build_ref();

    rst = 1'b1;
    a_valid = 0; a_inv = 0; a_data = '0; a_iready = 1'b1;
    b_valid = 0; b_inv = 0; b_data = '0; b_iready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_ready_a", 64'(a_ready), 64'd1);
    check("rst_ready_b", 64'(b_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid_a", 64'(a_ovalid), 64'd0);
    check("rst_busy_a", 64'(a_busy), 64'd0);
    check("rst_out_a", 64'({a_oinv, a_odata}), 64'd0);
    check("rst_valid_b", 64'(b_ovalid), 64'd0);
    check("rst_out_b", 64'({b_oinv, b_odata}), 64'd0);
    @(posedge clk); #1;

    // Known-answer vectors, two-cycle latency
    lat_check_a("kat_fwd", 32'h5300_01FF, 1'b0, {1'b0, 32'hED63_7C16});
    lat_check_a("kat_inv", 32'h5300_01FF, 1'b1, {1'b1, 32'h5052_097D});

    // Back-to-back stream; odd lane offset makes each byte value hit both modes
    ready_drops = 0;
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 4; k++) d[8*k +: 8] = 8'(i + 67 * k);
      a_valid = 1'b1; a_data = d; a_inv = 1'(i);
      @(negedge clk);
      if (!a_ready) ready_drops++;
      else exp_q_a.push_back(model_a(d, 1'(i)));
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    check("stream_ready_drops", 64'(ready_drops), 64'd0);
    drain("stream_drain");

    // Stall: downstream blocked for 5 cycles, exactly two words fit
    a_iready = 1'b0; n_acc = 0; have_hold = 0; hold = '0;
    a_valid = 1'b1; a_data = $urandom; a_inv = 1'($urandom_range(0, 1));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c >= 2) check("stall_ready", 64'(a_ready), 64'd0);
      if (a_ovalid) begin
        if (!have_hold) begin
          hold = {a_oinv, a_odata};
          have_hold = 1;
        end else check("stall_hold", 64'({a_oinv, a_odata}), 64'(hold));
      end
      acc = a_ready;
      if (acc) begin
        exp_q_a.push_back(model_a(a_data, a_inv));
        n_acc++;
      end
      @(posedge clk); #1;
      if (acc) begin a_data = $urandom; a_inv = 1'($urandom_range(0, 1)); end
    end
    a_valid = 1'b0;
    check("stall_accepted", 64'(n_acc), 64'd2);
    a_iready = 1'b1;
    drain("stall_drain");

    // Reset with two words held in the pipe
    a_iready = 1'b0;
    send_a($urandom, 1'b0);
    send_a($urandom, 1'b1);
    rst = 1'b1;
    exp_q_a.delete();
    @(negedge clk);
    check("midrst_ready", 64'(a_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", 64'(a_ovalid), 64'd0);
    check("midrst_busy", 64'(a_busy), 64'd0);
    @(posedge clk); #1;
    a_iready = 1'b1;
    d = $urandom;
    lat_check_a("post_rst", d, 1'b1, model_a(d, 1'b1));

    // Random traffic with random downstream back-pressure
    a_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      a_iready = ($urandom_range(0, 3) != 0);
      if (!a_valid && $urandom_range(0, 4) != 0) begin
        a_valid = 1'b1; a_data = $urandom; a_inv = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      acc = a_valid && a_ready;
      if (acc) exp_q_a.push_back(model_a(a_data, a_inv));
      @(posedge clk); #1;
      if (acc) a_valid = 1'b0;
    end
    a_valid = 1'b0;
    a_iready = 1'b1;
    drain("rand_a_drain");

    // Single-lane, unregistered output: one-cycle latency
    b_valid = 1'b1; b_data = 8'h00; b_inv = 1'b0;
    @(negedge clk);
    check("b_kat_accept", 64'(b_ready), 64'd1);
    exp_q_b.push_back({1'b0, 8'h63});
    @(posedge clk); #1;
    b_valid = 1'b0;
    @(negedge clk);
    check("b_kat_valid", 64'(b_ovalid), 64'd1);
    check("b_kat_data", 64'({b_oinv, b_odata}), {55'd0, 1'b0, 8'h63});
    @(posedge clk); #1;

    for (int c = 0; c < 300; c++) begin
      b_iready = ($urandom_range(0, 2) != 0);
      if (!b_valid && $urandom_range(0, 3) != 0) begin
        b_valid = 1'b1; b_data = 8'($urandom); b_inv = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (b_ovalid && !b_iready) check("b_stall_ready", 64'(b_ready), 64'd0);
      acc = b_valid && b_ready;
      if (acc) exp_q_b.push_back({b_inv, sub_ref(b_data, b_inv)});
      @(posedge clk); #1;
      if (acc) b_valid = 1'b0;
    end
    b_valid = 1'b0;
    b_iready = 1'b1;
    drain("final_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
